// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join job scheduler: join modes, per-job states,
// join results and controller FSM states.
package fork_join_pkg;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    JOB_IDLE     = 2'd0,
    JOB_RUNNING  = 2'd1,
    JOB_FINISHED = 2'd2,
    JOB_KILLED   = 2'd3
  } job_state_e;

  typedef enum logic [1:0] {
    JOIN_OK       = 2'd0,
    JOIN_TIMEOUT  = 2'd1,
    JOIN_DISABLED = 2'd2
  } join_result_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_KILL   = 3'd3,
    S_DONE   = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/fork_join_timer.sv
// Saturating wait counter with synchronous clear; hit flags the last cycle
// before the limit is reached (limit of zero never hits).
module fork_join_timer #(
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] limit,
  output logic          hit
);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (clr)
      count_q <= '0;
    else if (en && (count_q != '1))
      count_q <= count_q + 1'b1;
  end

  assign hit = (limit != '0) && (count_q == (limit - 1'b1));

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches a job set, tracks per-job state, resolves
// the join (all/any/none), kills losers, handles timeout and disable_fork.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int unsigned N_JOBS = 3,
  parameter int unsigned TW     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fork_valid,
  output logic                  fork_ready,
  input  logic [N_JOBS-1:0]     fork_mask,
  input  logic [1:0]            fork_mode,
  input  logic [TW-1:0]         timeout_cycles,
  input  logic                  disable_fork,
  output logic [N_JOBS-1:0]     job_start,
  input  logic [N_JOBS-1:0]     job_done,
  output logic [N_JOBS-1:0]     job_kill,
  output logic [2*N_JOBS-1:0]   job_status,
  output logic                  join_done,
  output logic [1:0]            join_status,
  output logic [N_JOBS-1:0]     join_finished
);

  fsm_state_e        state_q, state_d;
  join_mode_e        mode_q;
  join_result_e      result_q;
  job_state_e        status_q [N_JOBS];
  logic [TW-1:0]     tmo_q;
  logic [N_JOBS-1:0] join_set_q, join_fin_q, kill_q;
  logic [N_JOBS-1:0] running, done_ok, fin_all, start_now, kill_now;
  logic              accept, timer_hit, satisfied, others_running, in_flight;

  always_comb begin
    running = '0;
    for (int unsigned i = 0; i < N_JOBS; i++)
      running[i] = (status_q[i] == JOB_RUNNING);
  end

  assign accept         = fork_valid && (state_q == S_IDLE);
  assign done_ok        = running & job_done;
  assign fin_all        = join_fin_q | (join_set_q & done_ok);
  assign others_running = |(join_set_q & running & ~job_done);
  assign in_flight      = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_KILL);
  assign satisfied      = ((mode_q == JOIN_ALL) && ((fin_all & join_set_q) == join_set_q)) ||
                          ((mode_q == JOIN_ANY) && (|fin_all));

  fork_join_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == S_LAUNCH),
    .en    (state_q == S_WAIT),
    .limit (tmo_q),
    .hit   (timer_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = ((fork_mask & ~running) == '0) ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_d = (mode_q == JOIN_NONE) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (satisfied)      state_d = (mode_q == JOIN_ANY && others_running) ? S_KILL : S_DONE;
        else if (timer_hit) state_d = S_KILL;
      end
      S_KILL:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (disable_fork && in_flight) state_d = S_DONE;
  end

  // A done arriving during the KILL cycle beats the kill for that job.
  always_comb begin
    fork_ready = (state_q == S_IDLE);
    join_done  = (state_q == S_DONE);
    start_now  = (state_q == S_LAUNCH) ? join_set_q : '0;
    kill_now   = kill_q;
    if (state_q == S_KILL) kill_now = kill_now | (join_set_q & running & ~job_done);
  end

  assign job_start     = start_now;
  assign job_kill      = kill_now;
  assign join_status   = result_q;
  assign join_finished = join_fin_q;

  // Disable kills land one cycle later; jobs already being killed are excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      join_set_q <= '0;
      join_fin_q <= '0;
      kill_q     <= '0;
      mode_q     <= JOIN_ALL;
      tmo_q      <= '0;
      result_q   <= JOIN_OK;
    end else begin
      kill_q <= disable_fork ? ((running & ~job_done & ~kill_now) | start_now) : '0;
      if (accept) begin
        join_set_q <= fork_mask & ~running;
        join_fin_q <= '0;
        mode_q     <= join_mode_e'(fork_mode);
        tmo_q      <= timeout_cycles;
        result_q   <= JOIN_OK;
      end
      if (state_q == S_WAIT || state_q == S_KILL)
        join_fin_q <= fin_all;
      if (state_q == S_WAIT && !satisfied && timer_hit)
        result_q <= JOIN_TIMEOUT;
      if (disable_fork && in_flight)
        result_q <= JOIN_DISABLED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_JOBS; i++) status_q[i] <= JOB_IDLE;
    end else begin
      for (int unsigned i = 0; i < N_JOBS; i++) begin
        if (start_now[i])     status_q[i] <= JOB_RUNNING;
        else if (kill_now[i]) status_q[i] <= JOB_KILLED;
        else if (done_ok[i])  status_q[i] <= JOB_FINISHED;
      end
    end
  end

  always_comb begin
    job_status = '0;
    for (int unsigned i = 0; i < N_JOBS; i++)
      job_status[2*i +: 2] = status_q[i];
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboard bench for fork_join_ctrl: expected start/kill/join events are
// queued with their cycle when a command is issued and matched as they appear.
module tb_fork_join_ctrl;
  import fork_join_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fork_valid = 1'b0;
  logic        fork_ready;
  logic [2:0]  fork_mask = '0;
  logic [1:0]  fork_mode = '0;
  logic [15:0] timeout_cycles = '0;
  logic        disable_fork = 1'b0;
  logic [2:0]  job_start;
  logic [2:0]  job_done = '0;
  logic [2:0]  job_kill;
  logic [5:0]  job_status;
  logic        join_done;
  logic [1:0]  join_status;
  logic [2:0]  join_finished;

  fork_join_ctrl #(.N_JOBS(3), .TW(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fork_valid     (fork_valid),
    .fork_ready     (fork_ready),
    .fork_mask      (fork_mask),
    .fork_mode      (fork_mode),
    .timeout_cycles (timeout_cycles),
    .disable_fork   (disable_fork),
    .job_start      (job_start),
    .job_done       (job_done),
    .job_kill       (job_kill),
    .job_status     (job_status),
    .join_done      (join_done),
    .join_status    (join_status),
    .join_finished  (join_finished)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int           c;
    logic [2:0]   start;
    logic [2:0]   kill;
    logic         done;
    join_result_e jst;
    logic [2:0]   jfin;
  } ev_t;

  ev_t sb[$];
  ev_t e;

  task automatic push(input int c, input logic [2:0] s, input logic [2:0] k,
                      input logic d, input join_result_e js, input logic [2:0] jf);
    ev_t x;
    x.c = c; x.start = s; x.kill = k; x.done = d; x.jst = js; x.jfin = jf;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n && (job_start != '0 || job_kill != '0 || join_done)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 32'({job_start, job_kill, join_done}), 'h0);
      end else begin
        e = sb.pop_front();
        check("ev_cycle", 32'(cyc), 32'(e.c));
        check("ev_start", 32'(job_start), 32'(e.start));
        check("ev_kill", 32'(job_kill), 32'(e.kill));
        check("ev_join_done", 32'(join_done), 32'(e.done));
        if (e.done) begin
          check("ev_join_status", 32'(join_status), 32'(e.jst));
          check("ev_join_finished", 32'(join_finished), 32'(e.jfin));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_done(input logic [2:0] m);
    job_done = m;
    step();
    job_done = '0;
  endtask

  task automatic do_fork(input logic [2:0] mask, input join_mode_e mode, input logic [15:0] tmo);
    check("fork_ready", 32'(fork_ready), 'h1);
    fork_valid = 1'b1; fork_mask = mask; fork_mode = mode; timeout_cycles = tmo;
    step();
    fork_valid = 1'b0; fork_mask = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(fork_ready), 'h1);
    check({tag, "_start"}, 32'(job_start), 'h0);
    check({tag, "_kill"}, 32'(job_kill), 'h0);
    check({tag, "_join_done"}, 32'(join_done), 'h0);
    check({tag, "_status"}, 32'(job_status), 'h0);
    check({tag, "_join_status"}, 32'(join_status), 'h0);
    check({tag, "_join_fin"}, 32'(join_finished), 'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    int t2;
    repeat (3) step();
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("after_reset");

    // JOIN_NONE on a, then an empty join set while a is detached
    t = cyc;
    push(t + 1, 3'b001, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 2, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b000);
    do_fork(3'b001, JOIN_NONE, 16'd0);
    wait_until(t + 2);
    check("a_running", 32'(job_status), 'b000001);
    wait_until(t + 3);
    t2 = cyc;
    push(t2 + 1, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b000);
    do_fork(3'b001, JOIN_ALL, 16'd0);
    wait_until(t + 50);
    pulse_done(3'b001);
    check("a_finished", 32'(job_status), 'b000010);
    check("a_jfin_hold", 32'(join_finished), 'h0);

    // restart a detached
    t = cyc;
    push(t + 1, 3'b001, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 2, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b000);
    do_fork(3'b001, JOIN_NONE, 16'd0);
    wait_until(t + 3);
    check("a_restarted", 32'(job_status), 'b000001);

    // JOIN_ANY b,c: b wins, c killed
    t = cyc;
    push(t + 1, 3'b110, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 8, 3'b000, 3'b100, 1'b0, JOIN_OK, 3'b000);
    push(t + 9, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b010);
    do_fork(3'b110, JOIN_ANY, 16'd0);
    wait_until(t + 7);
    pulse_done(3'b010);
    wait_until(t + 10);
    check("any_status", 32'(job_status), 'b111001);

    // JOIN_ALL 111 with a running: only b,c joined
    t = cyc;
    push(t + 1, 3'b110, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 9, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b110);
    do_fork(3'b111, JOIN_ALL, 16'd0);
    wait_until(t + 4);
    pulse_done(3'b010);
    wait_until(t + 8);
    pulse_done(3'b100);
    wait_until(t + 10);
    check("all_status", 32'(job_status), 'b101001);

    // JOIN_ALL with timeout 4
    t = cyc;
    push(t + 1, 3'b110, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 6, 3'b000, 3'b110, 1'b0, JOIN_OK, 3'b000);
    push(t + 7, 3'b000, 3'b000, 1'b1, JOIN_TIMEOUT, 3'b000);
    do_fork(3'b110, JOIN_ALL, 16'd4);
    wait_until(t + 8);
    check("tmo_status", 32'(job_status), 'b111101);

    // JOIN_ANY with simultaneous dones
    t = cyc;
    push(t + 1, 3'b110, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 5, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b110);
    do_fork(3'b110, JOIN_ANY, 16'd0);
    wait_until(t + 4);
    pulse_done(3'b110);
    wait_until(t + 6);
    check("any2_status", 32'(job_status), 'b101001);

    // JOIN_ANY with c's done landing in the KILL cycle
    t = cyc;
    push(t + 1, 3'b110, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 6, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b110);
    do_fork(3'b110, JOIN_ANY, 16'd0);
    wait_until(t + 4);
    pulse_done(3'b010);
    job_done = 3'b100;
    @(negedge clk);
    check("kill_cycle_no_kill", 32'(job_kill), 'h0);
    step();
    job_done = '0;
    wait_until(t + 7);
    check("killcyc_status", 32'(job_status), 'b101001);

    // timeout of 1 cycle
    t = cyc;
    push(t + 1, 3'b010, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 3, 3'b000, 3'b010, 1'b0, JOIN_OK, 3'b000);
    push(t + 4, 3'b000, 3'b000, 1'b1, JOIN_TIMEOUT, 3'b000);
    do_fork(3'b010, JOIN_ANY, 16'd1);
    wait_until(t + 5);
    check("tmo1_status", 32'(job_status), 'b101101);

    // done in the timeout cycle wins
    t = cyc;
    push(t + 1, 3'b100, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 5, 3'b000, 3'b000, 1'b1, JOIN_OK, 3'b100);
    do_fork(3'b100, JOIN_ALL, 16'd3);
    wait_until(t + 4);
    pulse_done(3'b100);
    wait_until(t + 6);
    check("tmo_race_jst", 32'(join_status), 32'(JOIN_OK));

    // disable_fork in WAIT kills joined and detached jobs
    t = cyc;
    push(t + 1, 3'b110, 3'b000, 1'b0, JOIN_OK, 3'b000);
    push(t + 5, 3'b000, 3'b111, 1'b1, JOIN_DISABLED, 3'b000);
    do_fork(3'b110, JOIN_ALL, 16'd0);
    wait_until(t + 4);
    disable_fork = 1'b1;
    step();
    disable_fork = 1'b0;
    wait_until(t + 6);
    check("dis_status", 32'(job_status), 'b111111);
    check("dis_jst", 32'(join_status), 32'(JOIN_DISABLED));

    // reset asserted in the middle of LAUNCH
    t = cyc;
    push(t + 1, 3'b011, 3'b000, 1'b0, JOIN_OK, 3'b000);
    do_fork(3'b011, JOIN_ALL, 16'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    check_idle_outputs("post_reset");

    check("sb_empty", 32'(sb.size()), 'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
